// File: rtl/sym_packer.sv
// sym_packer: drains a first-word-fall-through symbol FiFo and packs SYMS
// consecutive symbols into one wide word. The word is presented on a
// valid/ready handshake. A flush request emits a partially filled word, so
// tail symbols are never stranded in the packing register.
module sym_packer #(
    parameter int SYM_W = 2,
    parameter int SYMS  = 4,
    parameter int CNT_W = $clog2(SYMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SYM_W-1:0]        fifo_dout,
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic                    flush,
    output logic [SYM_W*SYMS-1:0]   out_data,
    output logic [CNT_W-1:0]        out_cnt,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int              WORD_W   = SYM_W * SYMS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SYMS);

    typedef enum logic {
        FILL = 1'b0,  // accumulating symbols into the packing register
        HOLD = 1'b1   // presenting a word, waiting for the sink
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;   // symbols already in pack_q
    logic [WORD_W-1:0]  pack_q,  pack_d;    // packing register
    logic [CNT_W-1:0]   cnt_q,   cnt_d;     // symbol count of the held word
    logic [CNT_W-1:0]   n_syms;             // fill level including this cycle's pop

    // Pop whenever a head symbol exists and there is room for it. In HOLD the
    // slot-0 position frees up in the same cycle the sink accepts the word,
    // which keeps streaming bubble-free. Reset gates the strobe so the FiFo
    // is never drained while this block is held in reset.
    always_comb begin
        fifo_pop = rst && !fifo_empty && ((state_q == FILL) || out_ready);
    end

    // Next-state, packing and count logic.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; otherwise synthesis would infer a latch.
        state_d = state_q;
        count_d = count_q;
        pack_d  = pack_q;
        cnt_d   = cnt_q;
        n_syms  = count_q + CNT_W'(fifo_pop);

        case (state_q)
            FILL: begin
                if (fifo_pop) begin
                    pack_d[count_q*SYM_W +: SYM_W] = fifo_dout;
                end
                // A full word and a flush of a non-empty word leave the same
                // way; a flush with nothing collected is simply ignored.
                if ((n_syms == FULL_CNT) || (flush && (n_syms != '0))) begin
                    state_d = HOLD;
                    cnt_d   = n_syms;
                    count_d = '0;
                end else begin
                    count_d = n_syms;
                end
            end

            HOLD: begin
                // flush is ignored here; the word stays stable until accepted.
                if (out_ready) begin
                    state_d = FILL;
                    cnt_d   = '0;
                    pack_d  = '0;
                    count_d = CNT_W'(fifo_pop);
                    if (fifo_pop) begin
                        pack_d[SYM_W-1:0] = fifo_dout;
                    end
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // State, count and packing registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the packing register is reset as well: unfilled upper slots of
        // a flushed word must read as zero, and that relies on a cleared
        // register at the start of every word, including the first.
        if (!rst) begin
            state_q <= FILL;
            count_q <= '0;
            pack_q  <= '0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational block.
            state_q <= state_d;
            count_q <= count_d;
            pack_q  <= pack_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output view: data is only exposed while a word is being presented.
    always_comb begin
        out_valid = (state_q == HOLD);
        out_data  = out_valid ? pack_q : '0;
        out_cnt   = cnt_q;
    end

endmodule

// File: tb/tb_sym_packer.sv
// Directed self-checking bench for sym_packer with a small FWFT FiFo model.
module tb_sym_packer;

    logic       clk;
    logic       rst;
    logic [1:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       flush;
    logic [7:0] out_data;
    logic [2:0] out_cnt;
    logic       out_valid;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    sym_packer #(.SYM_W(2), .SYMS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FWFT FiFo model: writes come from the stimulus, reads follow fifo_pop.
    logic [1:0] mem [0:63];
    logic [5:0] wr_ptr = '0;
    logic [5:0] rd_ptr = '0;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_dout  = mem[rd_ptr];

    // Advance the read pointer on each accepted pop.
    always @(posedge clk) begin
        if (fifo_pop) rd_ptr <= rd_ptr + 6'd1;
    end

    task automatic push(input logic [1:0] s);
        mem[wr_ptr] = s;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // ---- 1: reset state, then a basic word 1,2,3,0 -> 8'h39 ----
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_cnt",   32'(out_cnt),   32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_pop",   32'(fifo_pop),  32'd0);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("t1_pop", 32'(fifo_pop), 32'd1);
            check("t1_nvalid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_data",  32'(out_data),  32'h39);
        check("t1_cnt",   32'(out_cnt),   32'd4);
        check("t1_pop_e", 32'(fifo_pop),  32'd0);
        @(negedge clk);
        check("t1_acc", 32'(out_valid), 32'd0);

        // ---- 2: backpressure, word 1,1,1,1 held, two more symbols waiting ----
        out_ready = 1'b0;
        push(2'd1); push(2'd1); push(2'd1); push(2'd1); push(2'd2); push(2'd2);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t2_valid", 32'(out_valid), 32'd1);
            check("t2_data",  32'(out_data),  32'h55);
            check("t2_pop",   32'(fifo_pop),  32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("t2_hs_pop", 32'(fifo_pop), 32'd1);
        @(negedge clk);
        check("t2_acc",   32'(out_valid), 32'd0);
        check("t2_pop2",  32'(fifo_pop),  32'd1);
        @(negedge clk);
        check("t2_empty_pop", 32'(fifo_pop), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        // Slot 0 came from the handshake pop, slot 1 from the next one.
        check("t2_fl_valid", 32'(out_valid), 32'd1);
        check("t2_fl_data",  32'(out_data),  32'h0A);
        check("t2_fl_cnt",   32'(out_cnt),   32'd2);
        @(negedge clk);
        check("t2_fl_acc", 32'(out_valid), 32'd0);

        // ---- 3: flush of a partial word 1,2 -> 8'h09, then empty flush ----
        push(2'd1); push(2'd2);
        repeat (2) @(negedge clk);
        check("t3_nvalid", 32'(out_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_data",  32'(out_data),  32'h09);
        check("t3_cnt",   32'(out_cnt),   32'd2);
        @(negedge clk);
        check("t3_acc", 32'(out_valid), 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("t3_empty_flush", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("t3_empty_flush2", 32'(out_valid), 32'd0);

        // ---- 4: streaming 0,1,2,3,3,2,1,0 -> 8'hE4 then 8'h1B ----
        push(2'd0); push(2'd1); push(2'd2); push(2'd3);
        push(2'd3); push(2'd2); push(2'd1); push(2'd0);
        #1;
        for (int i = 0; i <= 8; i++) begin
            check("t4_pop",   32'(fifo_pop),  (i < 8) ? 32'd1 : 32'd0);
            check("t4_valid", 32'(out_valid), (i == 4 || i == 8) ? 32'd1 : 32'd0);
            if (i == 4) check("t4_w0", 32'(out_data), 32'hE4);
            if (i == 8) check("t4_w1", 32'(out_data), 32'h1B);
            if (i == 4 || i == 8) check("t4_cnt", 32'(out_cnt), 32'd4);
            @(negedge clk);
        end
        check("t4_acc", 32'(out_valid), 32'd0);

        // ---- 5: asynchronous reset mid-fill ----
        push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        repeat (3) @(negedge clk);
        check("t5_pre_pop", 32'(fifo_pop), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_pop",   32'(fifo_pop),  32'd0);
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        wr_ptr = rd_ptr;  // FiFo is reset on its own
        @(negedge clk);
        rst = 1'b1;
        push(2'd2); push(2'd2); push(2'd2); push(2'd2);
        repeat (4) @(negedge clk);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_data",  32'(out_data),  32'hAA);
        check("t5_cnt",   32'(out_cnt),   32'd4);
        @(negedge clk);
        check("t5_acc", 32'(out_valid), 32'd0);

        // ---- 6: flush in the same cycle as a pop ----
        push(2'd3);
        @(negedge clk);
        push(2'd1);
        flush = 1'b1;
        #1;
        check("t6_pop", 32'(fifo_pop), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd1);
        check("t6_data",  32'(out_data),  32'h07);
        check("t6_cnt",   32'(out_cnt),   32'd2);
        @(negedge clk);
        check("t6_acc", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sym_packer.md
Name: sym_packer

Overview:
- Downstream consumer of the 2-bit FiFo. It drains the FiFo's first-word-fall-through head (dout/empty) by driving its pop.
- Packs SYMS consecutive symbols into one wide word and presents it on a valid/ready output handshake.
- A flush input emits a partially filled word, so tail symbols are never stranded.
- Sits between the FiFo and any word-wide sink.

Parameters:
- SYM_W, 2, width of one FiFo symbol; must match FiFo data width.
- SYMS, 4, symbols per output word (>=2).
- CNT_W, $clog2(SYMS+1), width of the symbol-count output.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low (block is in reset while rst==0).
- fifo_dout  in  SYM_W  FiFo head symbol; valid whenever fifo_empty==0.
- fifo_empty  in  1  FiFo empty flag.
- fifo_pop  out  1  pop strobe to FiFo (combinational).
- flush  in  1  single-cycle request to emit the current partial word.
- out_data  out  SYM_W*SYMS  packed word; first-popped symbol in bits [SYM_W-1:0].
- out_cnt  out  CNT_W  number of valid symbols in out_data (1..SYMS).
- out_valid  out  1  out_data/out_cnt valid.
- out_ready  in  1  sink accepts the word when out_valid && out_ready.

Behaviour:
- Reset (rst==0, asynchronous):
  - State=FILL, count=0, packing register=0.
  - out_valid=0, out_cnt=0, out_data=0.
  - fifo_pop is forced 0.
- States:
  - FILL accumulates symbols.
  - HOLD presents a word and waits for out_ready.
- Pop rule: fifo_pop = !fifo_empty && (state==FILL || (state==HOLD && out_ready)). At most one pop per cycle. fifo_dout is captured on the same clock edge as the pop.
- FILL, pop at count==k:
  - Symbol written to slot k, i.e. bits [k*SYM_W +: SYM_W].
  - count becomes k+1.
  - If k+1==SYMS: go to HOLD with out_cnt=SYMS and count=0.
- FILL, flush:
  - Let n = count + (pop this cycle ? 1 : 0).
  - If n>0: go to HOLD with out_cnt=n. Unfilled upper slots are zero, and count resets to 0.
  - If n==0: flush is ignored.
  - If n==SYMS, the behaviour is identical to a normal fill.
- HOLD:
  - out_valid=1. out_data and out_cnt stay stable until the handshake.
  - flush is ignored.
  - Handshake (out_ready==1): if a pop occurs the same cycle, the new symbol goes to slot 0 of a cleared register and count=1; otherwise the register is cleared and count=0. The state returns to FILL, or stays in HOLD if SYMS==1 is disallowed (SYMS>=2).
- Throughput: with out_ready held 1 and the FiFo never empty, one symbol is popped every cycle and one word is emitted every SYMS cycles, with zero bubbles.
- Latency: the first pop of a word to out_valid is SYMS clock edges; the flushed symbol to out_valid is 1 edge.
- fifo_empty==1: never pop, and the packing register holds.
- Reset mid-word: partial data is discarded and no word is emitted. fifo_pop returns to 0 immediately; the FiFo is reset separately.
- out_valid never deasserts without a handshake, except on reset.

Test Plan:
- Reset, then push 1,2,3,0 into the FiFo, out_ready=1. Expect:
  - 4 pops on consecutive cycles once the FiFo is non-empty.
  - out_valid=1, out_data=8'h39, out_cnt=4.
  - Accepted the next cycle, then out_valid=0.
- Backpressure: fill word 1,1,1,1 with out_ready=0 and push 2 more symbols. Expect:
  - out_data=8'h55 is held stable with fifo_pop=0 for 5 cycles.
  - Raising out_ready pops 1 symbol in the handshake cycle (count=1).
- Flush partial: push 1,2, then pulse flush once the FiFo is empty. Expect out_data=8'h09, out_cnt=2, out_valid=1. A flush with count 0 and an empty FiFo produces no out_valid.
- Streaming: continuous supply of 8 symbols 0,1,2,3,3,2,1,0, out_ready=1. Expect words 8'hE4 then 8'h1B, emitted 4 cycles apart with no idle pop cycles.
- Reset mid-fill: after 3 pops, drive rst=0 asynchronously. Expect:
  - out_valid=0 and fifo_pop=0 immediately.
  - After release, push 2,2,2,2, giving out_data=8'hAA and out_cnt=4; no stale symbols.
- Simultaneous flush and pop: count=1 (symbol 3), FiFo head=1, flush=1. Expect the pop occurs, out_data=8'h07, out_cnt=2.
